// File: rtl/cache_pkg.sv
// Shared types and geometry helpers for the direct-mapped cache controller.
package cache_pkg;

    localparam int CACHE_DW  = 128;
    localparam int CACHE_NUM = 8;
    localparam int CACHE_AW  = 32;

    function automatic int off_w(input int dw);
        return $clog2(dw / 8);
    endfunction

    function automatic int idx_w(input int num);
        return $clog2(num);
    endfunction

    function automatic int tag_w(input int aw, input int dw, input int num);
        return aw - off_w(dw) - idx_w(num);
    endfunction

    // Field widths for the default geometry.
    localparam int OFF_W = off_w(CACHE_DW);
    localparam int IDX_W = idx_w(CACHE_NUM);
    localparam int TAG_W = tag_w(CACHE_AW, CACHE_DW, CACHE_NUM);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOOKUP    = 3'd1,
        WB        = 3'd2,
        FILL_REQ  = 3'd3,
        FILL_WAIT = 3'd4,
        RESP      = 3'd5
    } state_e;

endpackage

// File: rtl/cache_tag_array.sv
// Tag, valid and dirty storage: combinational lookup, synchronous update.
module cache_tag_array
    import cache_pkg::*;
#(
    parameter int NUM = CACHE_NUM,
    parameter int TW  = TAG_W,
    localparam int IW = idx_w(NUM)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [IW-1:0] lkp_idx_i,
    output logic          lkp_valid_o,
    output logic          lkp_dirty_o,
    output logic [TW-1:0] lkp_tag_o,
    input  logic          upd_en_i,
    input  logic [IW-1:0] upd_idx_i,
    input  logic          upd_valid_i,
    input  logic          upd_dirty_i,
    input  logic [TW-1:0] upd_tag_i
);

    logic [NUM-1:0] valid_q;
    logic [NUM-1:0] dirty_q;
    logic [TW-1:0]  tag_q [NUM];

    // Reset invalidates every line; updates rewrite one entry in full.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            dirty_q <= '0;
            for (int i = 0; i < NUM; i++) begin
                tag_q[i] <= '0;
            end
        end else if (upd_en_i) begin
            valid_q[upd_idx_i] <= upd_valid_i;
            dirty_q[upd_idx_i] <= upd_dirty_i;
            tag_q[upd_idx_i]   <= upd_tag_i;
        end
    end

    assign lkp_valid_o = valid_q[lkp_idx_i];
    assign lkp_dirty_o = dirty_q[lkp_idx_i];
    assign lkp_tag_o   = tag_q[lkp_idx_i];

endmodule

// File: rtl/cache_ctrl.sv
// Direct-mapped write-back, write-allocate cache controller with an
// external data array and a single outstanding CPU request.
module cache_ctrl
    import cache_pkg::*;
#(
    parameter int DW  = CACHE_DW,
    parameter int NUM = CACHE_NUM,
    parameter int AW  = CACHE_AW,
    localparam int OFF_BITS = off_w(DW),
    localparam int IDX_BITS = idx_w(NUM),
    localparam int TAG_BITS = tag_w(AW, DW, NUM),
    localparam int BE_W     = DW / 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic                req_we_i,
    input  logic [AW-1:0]       req_addr_i,
    input  logic [31:0]         req_wdata_i,
    input  logic [3:0]          req_wstrb_i,
    output logic                resp_valid_o,
    output logic [31:0]         resp_rdata_o,
    output logic                mem_req_valid_o,
    input  logic                mem_req_ready_i,
    output logic                mem_req_we_o,
    output logic [AW-1:0]       mem_req_addr_o,
    output logic [DW-1:0]       mem_req_wdata_o,
    input  logic                mem_resp_valid_i,
    input  logic [DW-1:0]       mem_resp_rdata_i,
    output logic                da_read_en_o,
    output logic [IDX_BITS-1:0] da_read_addr_o,
    input  logic [DW-1:0]       da_read_data_i,
    output logic                da_write_en_o,
    output logic [BE_W-1:0]     da_write_byte_en_o,
    output logic [IDX_BITS-1:0] da_write_addr_o,
    output logic [DW-1:0]       da_write_data_o
);

    state_e        state_q, state_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [3:0]    wstrb_q, wstrb_d;
    logic [31:0]   resp_rdata_q, resp_rdata_d;

    logic [TAG_BITS-1:0] req_tag;
    logic [IDX_BITS-1:0] req_idx;
    logic [OFF_BITS-1:0] req_off;
    logic [OFF_BITS-1:0] word_sel;
    logic [31:0]         sel_word;
    logic [BE_W-1:0]     strb_line;
    logic [DW-1:0]       wdata_line;

    logic                tag_valid;
    logic                tag_dirty;
    logic [TAG_BITS-1:0] tag_rd;
    logic                hit;
    logic                upd_en;
    logic                upd_valid;
    logic                upd_dirty;

    assign req_tag    = addr_q[AW-1 -: TAG_BITS];
    assign req_idx    = addr_q[OFF_BITS +: IDX_BITS];
    assign req_off    = addr_q[OFF_BITS-1:0];
    assign word_sel   = req_off >> 2;
    assign sel_word   = da_read_data_i[{word_sel, 5'b00000} +: 32];
    assign strb_line  = BE_W'(wstrb_q) << {word_sel, 2'b00};
    assign wdata_line = {(DW / 32){wdata_q}};
    assign hit        = tag_valid && (tag_rd == req_tag);

    assign da_read_addr_o  = req_idx;
    assign da_write_addr_o = req_idx;
    assign resp_rdata_o    = resp_rdata_q;

    cache_tag_array #(
        .NUM (NUM),
        .TW  (TAG_BITS)
    ) u_tags (
        .clk         (clk),
        .rst         (rst),
        .lkp_idx_i   (req_idx),
        .lkp_valid_o (tag_valid),
        .lkp_dirty_o (tag_dirty),
        .lkp_tag_o   (tag_rd),
        .upd_en_i    (upd_en),
        .upd_idx_i   (req_idx),
        .upd_valid_i (upd_valid),
        .upd_dirty_i (upd_dirty),
        .upd_tag_i   (req_tag)
    );

    // State and latched request registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            resp_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

    // Next-state and output decode; reset forces every strobe low so an
    // interrupted memory transaction is dropped in the same cycle.
    always_comb begin
        state_d            = state_q;
        we_d               = we_q;
        addr_d             = addr_q;
        wdata_d            = wdata_q;
        wstrb_d            = wstrb_q;
        resp_rdata_d       = resp_rdata_q;
        req_ready_o        = 1'b0;
        resp_valid_o       = 1'b0;
        mem_req_valid_o    = 1'b0;
        mem_req_we_o       = 1'b0;
        mem_req_addr_o     = '0;
        mem_req_wdata_o    = '0;
        da_read_en_o       = 1'b0;
        da_write_en_o      = 1'b0;
        da_write_byte_en_o = '0;
        da_write_data_o    = '0;
        upd_en             = 1'b0;
        upd_valid          = 1'b0;
        upd_dirty          = 1'b0;

        case (state_q)
            IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    we_d    = req_we_i;
                    addr_d  = req_addr_i;
                    wdata_d = req_wdata_i;
                    wstrb_d = req_wstrb_i;
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                da_read_en_o = 1'b1;
                if (hit) begin
                    if (we_q) begin
                        da_write_en_o      = 1'b1;
                        da_write_byte_en_o = strb_line;
                        da_write_data_o    = wdata_line;
                        upd_en             = 1'b1;
                        upd_valid          = 1'b1;
                        upd_dirty          = 1'b1;
                        resp_rdata_d       = '0;
                    end else begin
                        resp_rdata_d = sel_word;
                    end
                    state_d = RESP;
                end else if (tag_valid && tag_dirty) begin
                    state_d = WB;
                end else begin
                    state_d = FILL_REQ;
                end
            end
            WB: begin
                // Read port stays enabled so the victim line is held stable.
                da_read_en_o    = 1'b1;
                mem_req_valid_o = 1'b1;
                mem_req_we_o    = 1'b1;
                mem_req_addr_o  = {tag_rd, req_idx, {OFF_BITS{1'b0}}};
                mem_req_wdata_o = da_read_data_i;
                if (mem_req_ready_i) begin
                    state_d = FILL_REQ;
                end
            end
            FILL_REQ: begin
                mem_req_valid_o = 1'b1;
                mem_req_addr_o  = {req_tag, req_idx, {OFF_BITS{1'b0}}};
                if (mem_req_ready_i) begin
                    state_d = FILL_WAIT;
                end
            end
            FILL_WAIT: begin
                if (mem_resp_valid_i) begin
                    da_write_en_o      = 1'b1;
                    da_write_byte_en_o = '1;
                    da_write_data_o    = mem_resp_rdata_i;
                    upd_en             = 1'b1;
                    upd_valid          = 1'b1;
                    upd_dirty          = 1'b0;
                    state_d            = LOOKUP;
                end
            end
            RESP: begin
                resp_valid_o = 1'b1;
                state_d      = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (rst) begin
            req_ready_o     = 1'b0;
            resp_valid_o    = 1'b0;
            mem_req_valid_o = 1'b0;
            da_read_en_o    = 1'b0;
            da_write_en_o   = 1'b0;
            upd_en          = 1'b0;
        end
    end

endmodule

// File: doc/cache_ctrl.md
CACHE_CTRL -- requirements
Module: cache_ctrl

Interface
REQ-001 Parameter DW, 128, cache line width in bits; power of two, at least 32.
REQ-002 Parameter NUM, 8, number of lines (direct-mapped); power of two.
REQ-003 Parameter AW, 32, byte address width.
REQ-004 clk  in  1  clock; all state changes on the rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 req_valid/req_ready  in/out  1  CPU request handshake.
REQ-007 req_we  in  1  1 = write, 0 = read.
REQ-008 req_addr  in  AW  byte address; bits [1:0] ignored.
REQ-009 req_wdata/req_wstrb  in  32/4  write word and its byte strobes.
REQ-010 resp_valid  out  1  one-cycle response pulse; no backpressure.
REQ-011 resp_rdata  out  32  read word, registered, held until the next response.
REQ-012 mem_req_valid/mem_req_ready  out/in  1  memory request handshake.
REQ-013 mem_req_we/mem_req_addr/mem_req_wdata  out  1/AW/DW  memory request; address is line-aligned.
REQ-014 mem_resp_valid/mem_resp_rdata  in  1/DW  refill line return.
REQ-015 da_read_en/da_read_addr/da_read_data  out/out/in  1/log2(NUM)/DW  data-array read port; read is combinational.
REQ-016 da_write_en/da_write_byte_en/da_write_addr/da_write_data  out  1/DW/8/log2(NUM)/DW  data-array write port; write is synchronous.

Function
REQ-017 Address split: offset = log2(DW/8) LSBs, word select = addr[offset-1:2], index = next log2(NUM) bits, tag = the remaining bits.
REQ-018 Tags, valid bits and dirty bits shall be held internally in flops.
REQ-019 The FSM shall have exactly the states IDLE, LOOKUP, WB, FILL_REQ, FILL_WAIT and RESP.
REQ-020 IDLE: req_ready=1; on req_valid&req_ready, latch we/addr/wdata/wstrb and go to LOOKUP; req_ready=0 in every other state.
REQ-021 LOOKUP: da_read_en=1, da_read_addr=index; hit = valid & tag match.
REQ-022 Read hit in LOOKUP: register the selected word into resp_rdata, then go to RESP.
REQ-023 Write hit in LOOKUP: da_write_en=1 in that same cycle; byte_en = wstrb shifted to the word lane; data = wdata replicated across the line; set dirty; go to RESP.
REQ-024 Miss in LOOKUP: go to WB if the victim is valid & dirty, otherwise go to FILL_REQ.
REQ-025 WB: mem_req_valid=1, we=1, addr={victim tag, index, 0}, wdata=da_read_data (read held enabled); advance to FILL_REQ on mem_req_ready.
REQ-026 FILL_REQ: mem_req_valid=1, we=0, addr={req tag, index, 0}; advance to FILL_WAIT on mem_req_ready.
REQ-027 While mem_req_valid=1 and mem_req_ready=0, all mem_req_* outputs shall stay stable.
REQ-028 FILL_WAIT, on mem_resp_valid: write the full line (all byte_en=1); set valid and tag; clear dirty; return to LOOKUP so the access replays as a hit.
REQ-029 mem_resp_valid outside FILL_WAIT shall be ignored.
REQ-030 RESP: resp_valid=1 for exactly one cycle, then go to IDLE.
REQ-031 Write responses shall drive resp_rdata=0.
REQ-032 Hit latency: request accepted at cycle T gives resp_valid at T+2; next request accepted at T+3.
REQ-033 The block shall allow only one outstanding request, with no hit-under-miss.

Reset
REQ-034 In rst: state=IDLE; all valid and dirty bits=0; resp_valid=0; resp_rdata=0; mem_req_valid=0; da_read_en=0; da_write_en=0.
REQ-035 Reset mid-operation shall abandon any memory transaction without completing it.
REQ-036 req_ready=1 from the first cycle after rst deasserts.

Structure
REQ-037 Package cache_pkg shall hold the state enum and the offset/index/tag width localparams as functions of DW, NUM and AW.
REQ-038 Tag, valid and dirty storage shall be the sub-module cache_tag_array: one combinational lookup port and one synchronous update port.

Verification (DW=128, NUM=8, AW=32)
REQ-039 Cold read 0x10 -> mem_req read addr 0x10; fill returns line L; resp_rdata=L[31:0]; no WB.
REQ-040 Read 0x14 after fill -> resp_valid at T+2; resp_rdata=L[63:32]; mem_req_valid stays 0.
REQ-041 Write 0x18, wdata 0xDEADBEEF, wstrb 0xF -> da_write_byte_en=0x0F00; dirty[1]=1; resp_rdata=0.
REQ-042 Read 0x90 (index 1, new tag) -> WB addr 0x10, wdata[95:64]=0xDEADBEEF; then fill 0x90; response returned.
REQ-043 mem_req_ready held 0 for 5 cycles in FILL_REQ -> mem_req_valid and mem_req_addr stable throughout.
REQ-044 rst asserted in FILL_WAIT; read 0x10 after release -> miss; new fill issued; a late mem_resp_valid is ignored.
